branch_resolve_unit: RTL

Execute-stage counterpart to the fetch-stage branch prediction path. Holds a pattern history table (PHT) of 2-bit saturating counters. Fetch reads a prediction combinationally. Execute reports each resolved conditional branch; the block then trains the indexed counter, detects mispredictions, and drives the PC redirect and pipeline flush back toward fetch.

---
 rtl/branch_resolve_unit_pkg.sv | 14 +
 rtl/sat_counter2.sv | 24 ++
 rtl/branch_resolve_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: 2-bit PHT counter encoding
// and the state every PHT entry takes on reset.
package branch_resolve_unit_pkg;

    typedef logic [1:0] bp_state_t;

    localparam bp_state_t STRONGLY_UNTAKEN = 2'b00;
    localparam bp_state_t WEAKLY_UNTAKEN   = 2'b01;
    localparam bp_state_t WEAKLY_TAKEN     = 2'b10;
    localparam bp_state_t STRONGLY_TAKEN   = 2'b11;

    localparam bp_state_t PHT_RESET_STATE  = WEAKLY_TAKEN;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
// Taken moves toward STRONGLY_TAKEN, not-taken toward STRONGLY_UNTAKEN.
module sat_counter2
    import branch_resolve_unit_pkg::*;
(
    input  bp_state_t state,
    input  logic      taken,
    output bp_state_t next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != STRONGLY_TAKEN) begin
                next_state = state + 2'd1;
            end
        end else begin
            if (state != STRONGLY_UNTAKEN) begin
                next_state = state - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: trains the PHT, flags mispredictions and
// drives the fetch redirect/flush plus a saturating mispredict counter.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_F,
    output logic        Predict_Taken_F,
    input  logic        Branch_E,
    input  logic        Stall_E,
    input  logic        Predict_Taken_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] Target_E,
    input  logic [31:0] PC_Plus_4_E,
    output logic        Redirect_En,
    output logic [31:0] Redirect_PC,
    output logic        Flush,
    output logic [15:0] Mispredict_Count
);

    localparam int ENTRIES = 1 << INDEX_W;

    bp_state_t pht_q [ENTRIES];
    bp_state_t pht_d [ENTRIES];
    logic [15:0] mispredict_count_q;
    logic [15:0] mispredict_count_d;

    logic [INDEX_W-1:0] idx_f;
    logic [INDEX_W-1:0] idx_e;
    logic               update_valid;
    logic               mispredict;
    bp_state_t          ctr_next;
    logic               unused_pc_bits;

    assign idx_f = PC_F[INDEX_W+1:2];
    assign idx_e = PC_E[INDEX_W+1:2];

    // Only the index field of each PC is used; the rest is deliberately dropped.
    assign unused_pc_bits = ^{PC_F, PC_E};

    assign update_valid = Branch_E & ~Stall_E;
    assign mispredict   = update_valid & (Predict_Taken_E != Branch_Taken_E);

    // No write bypass: fetch sees the pre-update counter in the update cycle.
    assign Predict_Taken_F = pht_q[idx_f][1];

    assign Redirect_En = mispredict;
    assign Flush       = mispredict;
    assign Redirect_PC = Branch_E ? (Branch_Taken_E ? Target_E : PC_Plus_4_E) : 32'h0;

    assign Mispredict_Count = mispredict_count_q;

    sat_counter2 u_sat_counter2 (
        .state      (pht_q[idx_e]),
        .taken      (Branch_Taken_E),
        .next_state (ctr_next)
    );

    always_comb begin
        pht_d = pht_q;
        if (update_valid) begin
            pht_d[idx_e] = ctr_next;
        end
    end

    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    // Register array rather than RAM so that every entry can be reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= PHT_RESET_STATE;
            end
            mispredict_count_q <= 16'h0;
        end else begin
            pht_q              <= pht_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
